// File: rtl/CPU_def.sv
// Shared CPU definitions: datapath/register widths, mul/div latencies,
// forward-select encoding and the mul/div tracker state type.
package CPU_def;

  localparam int PC_BITS    = 32;
  localparam int REG_BITS   = 5;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_BITS   = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // A producer hits a consumer only when it writes a nonzero register.
  function automatic logic reg_hit(logic [REG_BITS-1:0] dst, logic we,
                                   logic [REG_BITS-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/md_tracker.sv
// Multiply/divide occupancy tracker: counts down the unit latency and
// raises a one-cycle done pulse before returning to idle.
module md_tracker
  import CPU_def::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic div_i,
  input  logic hold_i,
  output logic busy_o,
  output logic done_o
);

  md_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, done_q;
  logic [CNT_BITS-1:0] load_val;

  assign load_val = div_i ? CNT_BITS'(DIV_CYCLES - 1) : CNT_BITS'(MUL_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = load_val;
        end
      end
      // A pipeline stall from a load/branch hazard freezes the countdown.
      MD_BUSY: begin
        if (!hold_i) begin
          if (cnt_q == '0) state_d = MD_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = load_val;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != MD_IDLE);
      done_q  <= (state_d == MD_DONE);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding for execute and the branch
// comparator, load/branch/mul-div stall generation.
module hazard_unit
  import CPU_def::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] write_reg_e,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                mem_to_reg_m,
  input  logic                branch_d,
  input  logic                md_use_d,
  input  logic                md_start_e,
  input  logic                md_div_e,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                forward_a_d,
  output logic                forward_b_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e,
  output logic                md_busy,
  output logic                md_done
);

  logic lw_stall, br_stall, md_stall, stall;

  // MEM is checked first so the younger result wins over WB.
  function automatic logic [1:0] ex_fwd(logic [REG_BITS-1:0] src,
                                        logic [REG_BITS-1:0] wr_m, logic we_m,
                                        logic [REG_BITS-1:0] wr_w, logic we_w);
    if (reg_hit(wr_m, we_m, src))      return FWD_MEM;
    else if (reg_hit(wr_w, we_w, src)) return FWD_WB;
    else                               return FWD_REG;
  endfunction

  assign forward_a_e = ex_fwd(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  assign forward_b_e = ex_fwd(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  assign forward_a_d = reg_hit(write_reg_m, reg_write_m, rs_d);
  assign forward_b_d = reg_hit(write_reg_m, reg_write_m, rt_d);

  assign lw_stall = reg_hit(write_reg_e, mem_to_reg_e, rs_d)
                  | reg_hit(write_reg_e, mem_to_reg_e, rt_d);

  assign br_stall = branch_d &
                    ( reg_hit(write_reg_e, reg_write_e,  rs_d)
                    | reg_hit(write_reg_e, reg_write_e,  rt_d)
                    | reg_hit(write_reg_m, mem_to_reg_m, rs_d)
                    | reg_hit(write_reg_m, mem_to_reg_m, rt_d));

  assign md_stall = md_use_d & md_busy;
  assign stall    = lw_stall | br_stall | md_stall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  md_tracker u_md_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start_e),
    .div_i   (md_div_e),
    .hold_i  (lw_stall | br_stall),
    .busy_o  (md_busy),
    .done_o  (md_done)
  );

endmodule
